demux_deser_2ch: RTL and testbench
==================================

// Module: demux_deser_2ch
// PURPOSE
//  Downstream consumer of the 1x2 bit demux. Collects the bit stream steered onto out1/out2,
//  packs each channel's bits into WIDTH-bit words, and presents each word on a valid/ready port.
//  Registered stage between the combinational demux and word-level logic.
// PARAMETERS
//  WIDTH      8   bits per word, legal range 2..32
//  MSB_FIRST  1   1: first received bit lands in word[WIDTH-1]; 0: first bit lands in word[0]
// PORTS
//  clk          in   1      single clock, all state on rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  bit_valid    in   1      qualifies s/out1/out2 this cycle
//  s            in   1      channel select as driven to demux (0 -> ch1, 1 -> ch2)
//  out1         in   1      demux output 1 (data bit for ch1)
//  out2         in   1      demux output 2 (data bit for ch2)
//  flush        in   1      sync: discard partial words in both channels
//  clr_ovf      in   1      sync: clear both sticky overflow flags
//  word1        out  WIDTH  ch1 completed word
//  word1_valid  out  1      ch1 word pending
//  word1_ready  in   1      ch1 consumer accepts
//  word2        out  WIDTH  ch2 completed word
//  word2_valid  out  1      ch2 word pending
//  word2_ready  in   1      ch2 consumer accepts
//  ovf1, ovf2   out  1      sticky: a completed word was dropped
// BEHAVIOUR
//  - Reset (async assert, sync release): word*=0, word*_valid=0, ovf*=0, shift regs=0, counts=0.
//  - Bit capture: when bit_valid=1, b = s ? out2 : out1 goes to channel (s ? 2 : 1).
//    The unselected channel is untouched. bit_valid=0 means no state change except the handshake.
//  - Shift: MSB_FIRST=1: sh <= {sh[WIDTH-2:0], b}. MSB_FIRST=0: sh <= {b, sh[WIDTH-1:1]}.
//    The count runs 0..WIDTH-1.
//  - Completion: a bit arrives with count==WIDTH-1. The count wraps to 0.
//    The completed value (sh shifted with b) is the new word.
//    Latency: word*_valid is high in the cycle after the last bit is presented.
//  - Output state per channel: IDLE (valid=0) / HOLD (valid=1).
//    IDLE + completion -> HOLD, word loaded.
//    HOLD + ready, no completion -> IDLE. word holds its last value.
//    HOLD + ready + completion -> HOLD with the new word (back-to-back, no bubble).
//    HOLD + no ready + completion -> HOLD, pending word kept, new word dropped, ovf set.
//    In HOLD, word is stable until accepted.
//  - flush=1: both counts and shift regs clear. Pending words and valids are unaffected.
//    If flush and bit_valid occur together, flush wins and the bit is discarded.
//  - clr_ovf=1 clears ovf1/ovf2. If an overflow event occurs in the same cycle, set wins.
//  - Reset mid-word or mid-hold: all state lost immediately. No word is emitted.
//  - Channels are fully independent. Both may complete or be accepted in the same cycle.
// STRUCTURE
//  - Shared package: localparams for channel encoding (CH1=1'b0, CH2=1'b1) and output states
//    ST_IDLE/ST_HOLD. The count width is $clog2(WIDTH).
//  - Sub-module demux_bit_packer holds one channel: shift reg, count, output FSM, ovf.
//    It has ports clk, rst_n, bit_en, bit_in, flush, clr_ovf, word, valid, ready, ovf.
//  - Top instantiates it twice.
//    Ch1 connections: bit_en=bit_valid&~s, bit_in=out1.
//    Ch2 connections: bit_en=bit_valid&s, bit_in=out2.
// TESTING (WIDTH=8 unless noted)
//  - s=0, bit_valid=1, out1 sequence 1,0,1,0,0,1,0,1 on 8 cycles, ready=1
//    -> word1=8'hA5 and word1_valid=1 for exactly 1 cycle after the 8th bit.
//    word2_valid stays 0.
//  - Interleave ch1 bits of 8'h3C with ch2 bits of 8'hC3 (alternating s)
//    -> both words correct, each channel completes independently.
//  - Hold word1_ready=0, send 16 ch1 bits (8'h11 then 8'h22)
//    -> word1 stays 8'h11 and ovf1=1. Later, ready=1 -> valid drops. clr_ovf -> ovf1=0.
//  - ready=1 on the exact completion cycle of a second word -> valid stays high.
//    The word changes 8'h11 -> 8'h22 with no gap.
//  - 4 ch1 bits, then flush, then 8 bits of 8'h5A -> word1=8'h5A.
//    Then 4 bits, rst_n low for 1 cycle, then 8 bits of 8'h0F -> word1=8'h0F, no stray word.
//  - MSB_FIRST=0: bits 1,0,1,0,0,1,0,1 -> word1=8'hA5 reversed = 8'hA5 bit-mirrored (8'hA5).
//    Also bits 1,1,0,0,0,0,0,0 -> 8'h03.

Source files
------------

// File: rtl/demux_deser_2ch_pkg.sv
// Shared definitions for the two-channel demux deserializer: channel
// encoding on the select line and the per-channel output handshake states.
package demux_deser_2ch_pkg;

    localparam logic CH1 = 1'b0;
    localparam logic CH2 = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } out_state_e;

endpackage

// File: rtl/demux_deser_2ch_if.sv
// Bit-stream input and word-level valid/ready outputs of the two-channel deserializer.
interface demux_deser_2ch_if #(
    parameter int unsigned WIDTH = 8
);
    logic             bit_valid;
    logic             s;
    logic             out1;
    logic             out2;
    logic             flush;
    logic             clr_ovf;
    logic [WIDTH-1:0] word1;
    logic             word1_valid;
    logic             word1_ready;
    logic [WIDTH-1:0] word2;
    logic             word2_valid;
    logic             word2_ready;
    logic             ovf1;
    logic             ovf2;

    modport master (
        output bit_valid, s, out1, out2, flush, clr_ovf, word1_ready, word2_ready,
        input  word1, word1_valid, word2, word2_valid, ovf1, ovf2
    );

    modport slave (
        input  bit_valid, s, out1, out2, flush, clr_ovf, word1_ready, word2_ready,
        output word1, word1_valid, word2, word2_valid, ovf1, ovf2
    );
endinterface

// File: rtl/demux_deser_2ch_packer.sv
// One deserializer channel: shifts bits into a WIDTH-bit word and holds each
// completed word on a valid/ready port, flagging words dropped while blocked.
module demux_bit_packer
    import demux_deser_2ch_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_en,
    input  logic             bit_in,
    input  logic             flush,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] word,
    output logic             valid,
    input  logic             ready,
    output logic             ovf
);

    localparam int unsigned   CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_next;
    logic [CW-1:0]    cnt;
    logic             take;
    logic             done;
    out_state_e       state;

    // A flush in the same cycle as a bit discards the bit.
    always_comb begin
        take    = bit_en & ~flush;
        done    = take & (cnt == LAST);
        sh_next = sh;
        if (MSB_FIRST) begin
            sh_next = {sh[WIDTH-2:0], bit_in};
        end else begin
            sh_next = {bit_in, sh[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh  <= '0;
            cnt <= '0;
        end else if (flush) begin
            sh  <= '0;
            cnt <= '0;
        end else if (take) begin
            sh  <= sh_next;
            cnt <= done ? '0 : CW'(cnt + CW'(1));
        end
    end

    // Output handshake: a pending word is never overwritten until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            word  <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (done) begin
                        word  <= sh_next;
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (ready) begin
                        if (done) begin
                            word <= sh_next;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if ((state == ST_HOLD) && !ready && done) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

    assign valid = (state == ST_HOLD);

endmodule

// File: rtl/demux_deser_2ch.sv
// Collects the two outputs of a 1x2 bit demux and packs each channel's bits
// into words presented on independent valid/ready ports.
module demux_deser_2ch
    import demux_deser_2ch_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    demux_deser_2ch_if.slave   bus
);

    logic en1;
    logic en2;

    always_comb begin
        en1 = bus.bit_valid & (bus.s == CH1);
        en2 = bus.bit_valid & (bus.s == CH2);
    end

    demux_bit_packer #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_ch1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bit_en  (en1),
        .bit_in  (bus.out1),
        .flush   (bus.flush),
        .clr_ovf (bus.clr_ovf),
        .word    (bus.word1),
        .valid   (bus.word1_valid),
        .ready   (bus.word1_ready),
        .ovf     (bus.ovf1)
    );

    demux_bit_packer #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_ch2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bit_en  (en2),
        .bit_in  (bus.out2),
        .flush   (bus.flush),
        .clr_ovf (bus.clr_ovf),
        .word    (bus.word2),
        .valid   (bus.word2_valid),
        .ready   (bus.word2_ready),
        .ovf     (bus.ovf2)
    );

endmodule

// File: tb/tb_demux_deser_2ch.sv
// Bench for demux_deser_2ch: an MSB-first and an LSB-first instance share one
// stimulus; a queue-level model is compared every cycle plus literal checks.
module tb_demux_deser_2ch;

    localparam int unsigned W = 8;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic bit_valid = 1'b0;
    logic s         = 1'b0;
    logic out1      = 1'b0;
    logic out2      = 1'b0;
    logic flush     = 1'b0;
    logic clr_ovf   = 1'b0;
    logic r1        = 1'b1;
    logic r2        = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    demux_deser_2ch_if #(.WIDTH(W)) bus0 ();
    demux_deser_2ch_if #(.WIDTH(W)) bus1 ();

    assign bus0.bit_valid = bit_valid;  assign bus1.bit_valid = bit_valid;
    assign bus0.s = s;                  assign bus1.s = s;
    assign bus0.out1 = out1;            assign bus1.out1 = out1;
    assign bus0.out2 = out2;            assign bus1.out2 = out2;
    assign bus0.flush = flush;          assign bus1.flush = flush;
    assign bus0.clr_ovf = clr_ovf;      assign bus1.clr_ovf = clr_ovf;
    assign bus0.word1_ready = r1;       assign bus1.word1_ready = r1;
    assign bus0.word2_ready = r2;       assign bus1.word2_ready = r2;

    demux_deser_2ch #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    demux_deser_2ch #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Received bits are kept in arrival order; a word is formed only when WIDTH bits exist.
    bit        bits [2][W];
    int        nbits [2];
    logic [W-1:0] m_word  [2][2];   // [dut][channel]
    logic         m_valid [2][2];
    logic         m_ovf   [2][2];

    function automatic logic [W-1:0] pack(input int c, input int d);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < int'(W); i++) begin
            if (d == 0) w[W-1-i] = bits[c][i];
            else        w[i]     = bits[c][i];
        end
        return w;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            nbits[c] = 0;
            for (int d = 0; d < 2; d++) begin
                m_word[d][c]  = '0;
                m_valid[d][c] = 1'b0;
                m_ovf[d][c]   = 1'b0;
            end
        end
    endtask

    task automatic model_step();
        bit           done;
        bit           rdy;
        bit           set;
        logic [W-1:0] w [2];
        for (int c = 0; c < 2; c++) begin
            done = 1'b0;
            w[0] = '0;
            w[1] = '0;
            if (flush) begin
                nbits[c] = 0;
            end else if (bit_valid && (int'(s) == c)) begin
                bits[c][nbits[c]] = (c == 0) ? out1 : out2;
                nbits[c]++;
                if (nbits[c] == int'(W)) begin
                    done     = 1'b1;
                    w[0]     = pack(c, 0);
                    w[1]     = pack(c, 1);
                    nbits[c] = 0;
                end
            end
            rdy = (c == 0) ? r1 : r2;
            for (int d = 0; d < 2; d++) begin
                set = 1'b0;
                if (m_valid[d][c]) begin
                    if (done && rdy)       m_word[d][c] = w[d];
                    else if (done)         set = 1'b1;
                    else if (rdy)          m_valid[d][c] = 1'b0;
                end else if (done) begin
                    m_valid[d][c] = 1'b1;
                    m_word[d][c]  = w[d];
                end
                if (set)          m_ovf[d][c] = 1'b1;
                else if (clr_ovf) m_ovf[d][c] = 1'b0;
            end
        end
    endtask

    // Outputs are compared on the falling edge; inputs for the next rising edge are stable then.
    always @(negedge clk) begin
        logic [W-1:0] a_word  [2][2];
        logic         a_valid [2][2];
        logic         a_ovf   [2][2];
        if (!rst_n) model_reset();
        a_word[0][0] = bus0.word1; a_valid[0][0] = bus0.word1_valid; a_ovf[0][0] = bus0.ovf1;
        a_word[0][1] = bus0.word2; a_valid[0][1] = bus0.word2_valid; a_ovf[0][1] = bus0.ovf2;
        a_word[1][0] = bus1.word1; a_valid[1][0] = bus1.word1_valid; a_ovf[1][0] = bus1.ovf1;
        a_word[1][1] = bus1.word2; a_valid[1][1] = bus1.word2_valid; a_ovf[1][1] = bus1.ovf2;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 2; c++) begin
                check($sformatf("model d%0d ch%0d word", d, c + 1), 32'(a_word[d][c]), 32'(m_word[d][c]));
                check($sformatf("model d%0d ch%0d valid", d, c + 1), 32'(a_valid[d][c]), 32'(m_valid[d][c]));
                check($sformatf("model d%0d ch%0d ovf", d, c + 1), 32'(a_ovf[d][c]), 32'(m_ovf[d][c]));
            end
        end
        if (rst_n) model_step();
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic c, input logic b);
        bit_valid = 1'b1;
        s         = c;
        if (c == 1'b0) begin out1 = b; out2 = 1'($urandom); end
        else           begin out2 = b; out1 = 1'($urandom); end
        tick();
    endtask

    // Sends the first n bits of v, most significant first.
    task automatic send_bits(input logic c, input logic [W-1:0] v, input int n);
        for (int i = 0; i < n; i++) send_bit(c, v[W-1-i]);
        bit_valid = 1'b0;
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;

        // reset values
        rst_n = 1'b0;
        tick();
        tick();
        check("reset word1", 32'(bus0.word1), 32'h0);
        check("reset word1_valid", 32'(bus0.word1_valid), 32'h0);
        check("reset ovf2", 32'(bus0.ovf2), 32'h0);
        rst_n = 1'b1;
        tick();

        // single ch1 word, bits 1,0,1,0,0,1,0,1
        send_bits(1'b0, 8'hA5, 8);
        check("a5 msb word1", 32'(bus0.word1), 32'hA5);
        check("a5 lsb word1", 32'(bus1.word1), 32'hA5);
        check("a5 word1_valid", 32'(bus0.word1_valid), 32'h1);
        check("a5 word2_valid", 32'(bus0.word2_valid), 32'h0);
        tick();
        check("a5 valid one cycle", 32'(bus0.word1_valid), 32'h0);

        // interleaved channels
        a = 8'h3C;
        b = 8'hC3;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b0, a[7-i]);
            if (i == 7) check("interleave word1", 32'(bus0.word1), 32'h3C);
            send_bit(1'b1, b[7-i]);
        end
        bit_valid = 1'b0;
        check("interleave word2", 32'(bus0.word2), 32'hC3);
        check("interleave word2_valid", 32'(bus0.word2_valid), 32'h1);
        tick();

        // overflow while blocked; set beats a simultaneous clr_ovf
        r1 = 1'b0;
        send_bits(1'b0, 8'h11, 8);
        a = 8'h22;
        send_bits(1'b0, a, 7);
        clr_ovf = 1'b1;
        send_bit(1'b0, a[0]);
        clr_ovf   = 1'b0;
        bit_valid = 1'b0;
        check("ovf word1 kept", 32'(bus0.word1), 32'h11);
        check("ovf ovf1 set", 32'(bus0.ovf1), 32'h1);
        check("ovf valid held", 32'(bus0.word1_valid), 32'h1);
        r1 = 1'b1;
        tick();
        check("ovf accept drops valid", 32'(bus0.word1_valid), 32'h0);
        check("ovf word holds after accept", 32'(bus0.word1), 32'h11);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("clr_ovf clears", 32'(bus0.ovf1), 32'h0);

        // accept exactly on the completion cycle of the next word
        r1 = 1'b0;
        send_bits(1'b0, 8'h11, 8);
        a = 8'h22;
        send_bits(1'b0, a, 7);
        check("b2b word before", 32'(bus0.word1), 32'h11);
        r1 = 1'b1;
        send_bit(1'b0, a[0]);
        bit_valid = 1'b0;
        check("b2b word1", 32'(bus0.word1), 32'h22);
        check("b2b valid no gap", 32'(bus0.word1_valid), 32'h1);
        check("b2b no ovf", 32'(bus0.ovf1), 32'h0);
        tick();

        // flush of a partial word, flush beating a concurrent bit
        send_bits(1'b0, 8'hF0, 4);
        flush     = 1'b1;
        bit_valid = 1'b1;
        s         = 1'b0;
        out1      = 1'b1;
        tick();
        flush     = 1'b0;
        bit_valid = 1'b0;
        send_bits(1'b0, 8'h5A, 8);
        check("flush word1", 32'(bus0.word1), 32'h5A);

        // reset mid-word
        send_bits(1'b0, 8'hF0, 4);
        rst_n = 1'b0;
        #1;
        check("midreset valid", 32'(bus0.word1_valid), 32'h0);
        check("midreset word", 32'(bus0.word1), 32'h0);
        tick();
        rst_n = 1'b1;
        send_bits(1'b0, 8'h0F, 7);
        check("post reset no stray word", 32'(bus0.word1_valid), 32'h0);
        send_bit(1'b0, 1'b1);
        bit_valid = 1'b0;
        check("post reset word1", 32'(bus0.word1), 32'h0F);

        // bit order: 1,1,0,0,0,0,0,0
        tick();
        send_bits(1'b0, 8'hC0, 8);
        check("order lsb word1", 32'(bus1.word1), 32'h03);
        check("order msb word1", 32'(bus0.word1), 32'hC0);
        tick();

        // mixed traffic checked by the model
        for (int i = 0; i < 400; i++) begin
            bit_valid = 1'($urandom_range(0, 3) != 0);
            s         = 1'($urandom);
            out1      = 1'($urandom);
            out2      = 1'($urandom);
            r1        = 1'($urandom_range(0, 2) != 0);
            r2        = 1'($urandom_range(0, 3) == 0);
            flush     = 1'($urandom_range(0, 40) == 0);
            clr_ovf   = 1'($urandom_range(0, 15) == 0);
            tick();
        end
        bit_valid = 1'b0;
        flush     = 1'b0;
        clr_ovf   = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
